// File: rtl/zbt_ctrl_pkg.sv
// Shared types and constants for the ZBT SSRAM command sequencer.
package zbt_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int unsigned WR_LAT_DEF = 2;
  localparam int unsigned RD_LAT_DEF = 4;
  localparam int unsigned MAX_BURST  = 4;
  localparam int unsigned LEN_W      = $clog2(MAX_BURST);

endpackage

// File: rtl/zbt_cmd_ctrl_if.sv
// User command/data bus plus pipe-stage signals of the ZBT command sequencer.
interface zbt_cmd_ctrl_if #(
  parameter int unsigned ASIZE  = 18,
  parameter int unsigned DSIZE  = 36,
  parameter int unsigned BWSIZE = 4
);
  logic              user_req;
  logic              user_rd_wr_n;
  logic [ASIZE-1:0]  user_addr;
  logic [1:0]        user_len;
  logic [BWSIZE-1:0] user_dm;
  logic              user_ack;
  logic              wdata_req;
  logic [DSIZE-1:0]  user_wdata;
  logic [DSIZE-1:0]  rdata;
  logic              rdata_valid;
  logic              busy;
  logic              cen_n;
  logic [ASIZE-1:0]  addr;
  logic              rd_wr_n;
  logic              addr_adv_ld_n;
  logic [BWSIZE-1:0] dm;
  logic [DSIZE-1:0]  data_out;
  logic              data_oe;
  logic [DSIZE-1:0]  rd_data_in;

  // User / pipe-stage side
  modport master (
    output user_req, user_rd_wr_n, user_addr, user_len, user_dm, user_wdata, rd_data_in,
    input  user_ack, wdata_req, rdata, rdata_valid, busy, cen_n, addr, rd_wr_n,
           addr_adv_ld_n, dm, data_out, data_oe
  );

  // Sequencer side
  modport slave (
    input  user_req, user_rd_wr_n, user_addr, user_len, user_dm, user_wdata, rd_data_in,
    output user_ack, wdata_req, rdata, rdata_valid, busy, cen_n, addr, rd_wr_n,
           addr_adv_ld_n, dm, data_out, data_oe
  );
endinterface

// File: rtl/zbt_lat_shift.sv
// Fixed-latency shift register carrying a data word and its valid bit.
module zbt_lat_shift #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Empty slots carry zero data so the output is quiet between words
  always_comb begin
    valid_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) data_d[i] = '0;
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/zbt_cmd_ctrl.sv
// ZBT SSRAM command sequencer: turns user bursts into registered pipe-stage
// commands, delays write data to the write latency and tags returning reads.
module zbt_cmd_ctrl
  import zbt_ctrl_pkg::*;
#(
  parameter int unsigned ASIZE  = 18,
  parameter int unsigned DSIZE  = 36,
  parameter int unsigned BWSIZE = 4,
  parameter int unsigned WR_LAT = WR_LAT_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  zbt_cmd_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ASIZE-1:0]  addr_q, addr_d;
  logic              rd_wr_n_q, rd_wr_n_d;
  logic              adv_ld_n_q, adv_ld_n_d;
  logic              cen_n_q, cen_n_d;
  logic [BWSIZE-1:0] dm_q, dm_d;
  logic              wdata_req_q, wdata_req_d;
  logic              ack_c;

  logic              wr_oe, wr_busy;
  logic [DSIZE-1:0]  wr_data;
  logic              rd_vld, rd_tag, rd_busy;

  // Next-state: cnt_q counts beats remaining after the one now on the outputs
  always_comb begin
    state_d     = ST_IDLE;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rd_wr_n_d   = 1'b1;
    adv_ld_n_d  = 1'b1;
    cen_n_d     = 1'b1;
    dm_d        = '0;
    wdata_req_d = 1'b0;
    ack_c       = bus.user_req && ((state_q == ST_IDLE) || (cnt_q == '0));

    if (ack_c) begin
      state_d     = ST_BURST;
      cnt_d       = bus.user_len;
      addr_d      = bus.user_addr;
      rd_wr_n_d   = bus.user_rd_wr_n;
      adv_ld_n_d  = 1'b0;
      cen_n_d     = 1'b0;
      dm_d        = bus.user_rd_wr_n ? '0 : bus.user_dm;
      wdata_req_d = !bus.user_rd_wr_n;
    end else if ((state_q == ST_BURST) && (cnt_q != '0)) begin
      state_d     = ST_BURST;
      cnt_d       = cnt_q - LEN_W'(1);
      rd_wr_n_d   = rd_wr_n_q;
      cen_n_d     = 1'b0;
      dm_d        = dm_q;
      wdata_req_d = wdata_req_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rd_wr_n_q   <= 1'b1;
      adv_ld_n_q  <= 1'b1;
      cen_n_q     <= 1'b1;
      dm_q        <= '0;
      wdata_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rd_wr_n_q   <= rd_wr_n_d;
      adv_ld_n_q  <= adv_ld_n_d;
      cen_n_q     <= cen_n_d;
      dm_q        <= dm_d;
      wdata_req_q <= wdata_req_d;
    end
  end

  zbt_lat_shift #(.WIDTH(DSIZE), .DEPTH(WR_LAT)) u_wr_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (wdata_req_q),
    .in_data   (bus.user_wdata),
    .out_valid (wr_oe),
    .out_data  (wr_data),
    .any_valid (wr_busy)
  );

  // Read tag marks which future rd_data_in cycles carry a requested word
  zbt_lat_shift #(.WIDTH(1), .DEPTH(RD_LAT)) u_rd_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (!cen_n_q && rd_wr_n_q),
    .in_data   (1'b1),
    .out_valid (rd_vld),
    .out_data  (rd_tag),
    .any_valid (rd_busy)
  );

  assign bus.user_ack      = ack_c;
  assign bus.wdata_req     = wdata_req_q;
  assign bus.cen_n         = cen_n_q;
  assign bus.addr          = addr_q;
  assign bus.rd_wr_n       = rd_wr_n_q;
  assign bus.addr_adv_ld_n = adv_ld_n_q;
  assign bus.dm            = dm_q;
  assign bus.data_out      = wr_data;
  assign bus.data_oe       = wr_oe;
  assign bus.rdata_valid   = rd_vld && rd_tag;
  assign bus.rdata         = (rd_vld && rd_tag) ? bus.rd_data_in : '0;
  assign bus.busy          = (state_q == ST_BURST) || wr_busy || rd_busy;

endmodule

// File: tb/tb_zbt_cmd_ctrl.sv
// Directed + random bench for zbt_cmd_ctrl against a cycle-indexed beat schedule model.
module tb_zbt_cmd_ctrl;

  localparam int ASIZE  = 18;
  localparam int DSIZE  = 36;
  localparam int BWSIZE = 4;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 4;
  localparam int NCYC   = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zbt_cmd_ctrl_if #(.ASIZE(ASIZE), .DSIZE(DSIZE), .BWSIZE(BWSIZE)) bus ();

  zbt_cmd_ctrl #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .BWSIZE(BWSIZE), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: which cycles carry a beat, and what that beat is
  int                cyc;
  int                last_beat;
  bit                beat_v   [NCYC];
  bit                beat_ld  [NCYC];
  bit                beat_rw  [NCYC];
  logic [ASIZE-1:0]  beat_addr[NCYC];
  logic [BWSIZE-1:0] beat_dm  [NCYC];
  logic [DSIZE-1:0]  wd_hist  [NCYC];
  logic [ASIZE-1:0]  addr_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCYC; i++) begin
      beat_v[i] = 1'b0; beat_ld[i] = 1'b0; beat_rw[i] = 1'b0;
      beat_addr[i] = '0; beat_dm[i] = '0; wd_hist[i] = '0;
    end
    cyc       = 0;
    last_beat = -1;
    addr_hold = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_cen_n",     64'(bus.cen_n), 64'd1);
    chk("rst_rd_wr_n",   64'(bus.rd_wr_n), 64'd1);
    chk("rst_adv_ld_n",  64'(bus.addr_adv_ld_n), 64'd1);
    chk("rst_addr",      64'(bus.addr), 64'd0);
    chk("rst_dm",        64'(bus.dm), 64'd0);
    chk("rst_wdata_req", 64'(bus.wdata_req), 64'd0);
    chk("rst_data_oe",   64'(bus.data_oe), 64'd0);
    chk("rst_data_out",  64'(bus.data_out), 64'd0);
    chk("rst_rvalid",    64'(bus.rdata_valid), 64'd0);
    chk("rst_rdata",     64'(bus.rdata), 64'd0);
    chk("rst_busy",      64'(bus.busy), 64'd0);
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance
  task automatic step(input bit req, input bit rw, input logic [ASIZE-1:0] a,
                      input logic [1:0] len, input logic [BWSIZE-1:0] m,
                      input logic [DSIZE-1:0] wd, output bit acked);
    bit               ack_e, bt, oe_e, rv_e, busy_e;
    logic [DSIZE-1:0] rdin;
    if (cyc >= NCYC - 16) begin
      $display("FAIL model_overflow cyc=%0d", cyc);
      $fatal(1);
    end
    rdin = DSIZE'({$urandom(), $urandom()});
    bus.user_req     = req;
    bus.user_rd_wr_n = rw;
    bus.user_addr    = a;
    bus.user_len     = len;
    bus.user_dm      = m;
    bus.user_wdata   = wd;
    bus.rd_data_in   = rdin;
    #1;
    ack_e = req && (cyc >= last_beat);
    bt    = beat_v[cyc];
    if (bt) addr_hold = beat_addr[cyc];
    chk("user_ack",  64'(bus.user_ack), 64'(ack_e));
    chk("cen_n",     64'(bus.cen_n), 64'(!bt));
    chk("adv_ld_n",  64'(bus.addr_adv_ld_n), bt ? 64'(!beat_ld[cyc]) : 64'd1);
    chk("rd_wr_n",   64'(bus.rd_wr_n), bt ? 64'(beat_rw[cyc]) : 64'd1);
    chk("addr",      64'(bus.addr), 64'(addr_hold));
    chk("dm",        64'(bus.dm), (bt && !beat_rw[cyc]) ? 64'(beat_dm[cyc]) : 64'd0);
    chk("wdata_req", 64'(bus.wdata_req), 64'(bt && !beat_rw[cyc]));
    oe_e = (cyc >= WR_LAT) && beat_v[cyc-WR_LAT] && !beat_rw[cyc-WR_LAT];
    chk("data_oe", 64'(bus.data_oe), 64'(oe_e));
    if (oe_e) chk("data_out", 64'(bus.data_out), 64'(wd_hist[cyc-WR_LAT]));
    rv_e = (cyc >= RD_LAT) && beat_v[cyc-RD_LAT] && beat_rw[cyc-RD_LAT];
    chk("rdata_valid", 64'(bus.rdata_valid), 64'(rv_e));
    if (rv_e) chk("rdata", 64'(bus.rdata), 64'(rdin));
    busy_e = 1'b0;
    for (int b = cyc - 8; b <= cyc; b++) begin
      if (b >= 0 && beat_v[b] && (cyc - b) <= (beat_rw[b] ? RD_LAT : WR_LAT)) busy_e = 1'b1;
    end
    chk("busy", 64'(bus.busy), 64'(busy_e));
    wd_hist[cyc] = wd;
    if (ack_e) begin
      for (int k = 0; k <= int'(len); k++) begin
        beat_v[cyc+1+k]    = 1'b1;
        beat_ld[cyc+1+k]   = (k == 0);
        beat_rw[cyc+1+k]   = rw;
        beat_addr[cyc+1+k] = a;
        beat_dm[cyc+1+k]   = m;
      end
      last_beat = cyc + 1 + int'(len);
    end
    acked = ack_e;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit ack;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 2'd0, '0, DSIZE'($urandom()), ack);
  endtask

  // Issue a command; hold req until acked or the bound expires
  task automatic issue(input bit rw, input logic [ASIZE-1:0] a, input logic [1:0] len,
                       input logic [BWSIZE-1:0] m);
    bit ack;
    int n;
    n = 0;
    do begin
      step(1'b1, rw, a, len, m, DSIZE'({$urandom(), $urandom()}), ack);
      n++;
    end while (!ack && n < 8);
    if (!ack) chk("ack_timeout", 64'(ack), 64'd1);
  endtask

  initial begin
    bit ack;
    bus.user_req = 1'b0; bus.user_rd_wr_n = 1'b0; bus.user_addr = '0; bus.user_len = '0;
    bus.user_dm = '0; bus.user_wdata = '0; bus.rd_data_in = '0;
    reset = 1'b1;
    model_clear();
    #12;
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    idle(2);

    // Single write; known data on the write beat
    step(1'b1, 1'b0, 18'h00010, 2'd0, 4'h0, 36'h0, ack);
    step(1'b0, 1'b0, 18'h0, 2'd0, 4'h0, 36'h123456789, ack);
    idle(4);

    // Single read
    issue(1'b1, 18'h00010, 2'd0, 4'h0);
    idle(6);

    // 4-beat write then 4-beat read, req held
    issue(1'b0, 18'h01230, 2'd3, 4'h0);
    issue(1'b1, 18'h04560, 2'd3, 4'hF);
    idle(8);

    // Masked write then read
    issue(1'b0, 18'h00200, 2'd1, 4'b0101);
    issue(1'b1, 18'h00300, 2'd1, 4'b0101);
    idle(8);

    // Alternating single-beat read/write, req always high
    for (int i = 0; i < 12; i++)
      step(1'b1, i[0], ASIZE'($urandom()), 2'd0, BWSIZE'($urandom()),
           DSIZE'({$urandom(), $urandom()}), ack);
    idle(8);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom()), ASIZE'($urandom()),
           2'($urandom()), BWSIZE'($urandom()), DSIZE'({$urandom(), $urandom()}), ack);
    idle(8);

    // Reset in the middle of a 4-beat read, after beat 1
    issue(1'b1, 18'h0ABCD, 2'd3, 4'h0);
    idle(2);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b0;
    model_clear();
    idle(10);
    issue(1'b0, 18'h00040, 2'd0, 4'h3);
    issue(1'b1, 18'h00040, 2'd2, 4'h0);
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
